// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES-128/192/256 key schedule, one 32-bit word per clock,
// round keys streamed as 128-bit valid/ready beats. Optional macro KEYEXP_STORE_EN keeps all round keys readable.
module key_expansion_seq_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        return SBOX_TAB[(11'd2047 - {a, 3'd0}) -: 8];
    endfunction

    assign o_s = sbox_f(i_a);
endmodule

module key_expansion_seq #(
    parameter int NK = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [32*NK-1:0]  i_key,
`ifdef KEYEXP_STORE_EN
    input  logic [3:0]        i_rd_idx,
    output logic [127:0]      o_rd_key,
    output logic              o_keys_valid,
`endif
    output logic              o_busy,
    output logic              o_rk_valid,
    input  logic              i_rk_ready,
    output logic [3:0]        o_rk_index,
    output logic [127:0]      o_rk_data,
    output logic              o_done
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("key_expansion_seq: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    function automatic logic [7:0] xtime_f(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        r_state;
    logic [31:0]   r_win [0:NK-1];
    logic [31:0]   r_buf [0:2];
    logic [5:0]    r_i;
    logic [2:0]    r_phase;
    logic [7:0]    r_rcon;
    logic          r_busy;
    logic          r_rk_valid;
    logic [3:0]    r_rk_index;
    logic [127:0]  r_rk_data;
    logic          r_done;

    state_t        w_state_nxt;
    logic          w_accept, w_gen, w_load, w_last_ack, w_slot_free, w_init, w_rcon_step;
    logic [31:0]   w_prev, w_old, w_rot, w_sub, w_word;

    // The window holds w[i-NK..i-1]; preloaded with the key it also yields key words for i<NK.
    assign w_prev = r_win[NK-1];
    assign w_old  = r_win[0];
    assign w_init = (r_i < 6'(NK));
    assign w_rot  = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_expansion_seq_sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
    end

    // Next schedule word from the window and the shared SubWord.
    always_comb begin
        w_word      = w_old ^ w_prev;
        w_rcon_step = 1'b0;
        if (w_init) begin
            w_word = w_old;
        end else if (r_phase == 3'd0) begin
            w_word      = w_old ^ w_sub ^ {r_rcon, 24'h000000};
            w_rcon_step = 1'b1;
        end else if (NK == 8 && r_phase == 3'd4) begin
            w_word = w_old ^ w_sub;
        end else begin
            w_word = w_old ^ w_prev;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_gen       = 1'b0;
        w_load      = 1'b0;
        w_last_ack  = 1'b0;
        w_slot_free = !r_rk_valid || i_rk_ready;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_i[1:0] != 2'd3) begin
                    w_gen = 1'b1;
                end else if (w_slot_free) begin
                    w_gen  = 1'b1;
                    w_load = 1'b1;
                end else begin
                    w_gen = 1'b0;
                end
                if (w_gen && r_i == 6'(NW - 1)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_rk_valid && i_rk_ready) begin
                    w_last_ack  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Word counter, window, rcon and assembly buffer; all hold on a stalled 4th-word cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i     <= 6'd0;
            r_phase <= 3'd0;
            r_rcon  <= 8'h01;
            for (int k = 0; k < NK; k++) r_win[k] <= 32'h0;
            for (int k = 0; k < 3; k++) r_buf[k] <= 32'h0;
        end else if (w_accept) begin
            r_i     <= 6'd0;
            r_phase <= 3'd0;
            r_rcon  <= 8'h01;
            for (int k = 0; k < NK; k++) r_win[k] <= i_key[32*(NK-1-k) +: 32];
        end else if (w_gen) begin
            r_i     <= r_i + 6'd1;
            r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
            if (w_rcon_step) r_rcon <= xtime_f(r_rcon);
            for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
            r_win[NK-1] <= w_word;
            case (r_i[1:0])
                2'd0:    r_buf[0] <= w_word;
                2'd1:    r_buf[1] <= w_word;
                2'd2:    r_buf[2] <= w_word;
                default: ;
            endcase
        end
    end

    // Output beat register, busy and done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_index <= 4'd0;
            r_rk_data  <= 128'h0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_ack;
            if (w_accept)        r_busy <= 1'b1;
            else if (w_last_ack) r_busy <= 1'b0;
            if (w_load) begin
                r_rk_valid <= 1'b1;
                r_rk_data  <= {r_buf[0], r_buf[1], r_buf[2], w_word};
                r_rk_index <= r_i[5:2];
            end else if (r_rk_valid && i_rk_ready) begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_rk_valid = r_rk_valid;
    assign o_rk_index = r_rk_index;
    assign o_rk_data  = r_rk_data;
    assign o_done     = r_done;

`ifdef KEYEXP_STORE_EN
    logic [127:0] r_store [0:NR];
    logic         r_keys_valid;

    // Round-key store, written on every accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k <= NR; k++) r_store[k] <= 128'h0;
            r_keys_valid <= 1'b0;
        end else begin
            if (r_rk_valid && i_rk_ready) r_store[r_rk_index] <= r_rk_data;
            if (w_accept)        r_keys_valid <= 1'b0;
            else if (w_last_ack) r_keys_valid <= 1'b1;
        end
    end

    assign o_rd_key     = (i_rd_idx <= 4'(NR)) ? r_store[i_rd_idx] : 128'h0;
    assign o_keys_valid = r_keys_valid;
`endif
endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: NK=4/6/8 instances, FIPS-197 vectors, backpressure and reset re-entry.
module tb_key_expansion_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] EXP4 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    logic         rst;
    logic [2:0]   start, rdy, busy, vld, done;
    logic [3:0]   idx [3];
    logic [127:0] data [3];
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
`ifdef KEYEXP_STORE_EN
    logic [3:0]   rd_idx [3];
    logic [127:0] rd_key [3];
    logic [2:0]   kv;
`endif

    key_expansion_seq #(.NK(4)) u_nk4 (.i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_key(key4),
`ifdef KEYEXP_STORE_EN
        .i_rd_idx(rd_idx[0]), .o_rd_key(rd_key[0]), .o_keys_valid(kv[0]),
`endif
        .o_busy(busy[0]), .o_rk_valid(vld[0]), .i_rk_ready(rdy[0]), .o_rk_index(idx[0]),
        .o_rk_data(data[0]), .o_done(done[0]));
    key_expansion_seq #(.NK(6)) u_nk6 (.i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_key(key6),
`ifdef KEYEXP_STORE_EN
        .i_rd_idx(rd_idx[1]), .o_rd_key(rd_key[1]), .o_keys_valid(kv[1]),
`endif
        .o_busy(busy[1]), .o_rk_valid(vld[1]), .i_rk_ready(rdy[1]), .o_rk_index(idx[1]),
        .o_rk_data(data[1]), .o_done(done[1]));
    key_expansion_seq #(.NK(8)) u_nk8 (.i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_key(key8),
`ifdef KEYEXP_STORE_EN
        .i_rd_idx(rd_idx[2]), .o_rd_key(rd_key[2]), .o_keys_valid(kv[2]),
`endif
        .o_busy(busy[2]), .o_rk_valid(vld[2]), .i_rk_ready(rdy[2]), .o_rk_index(idx[2]),
        .o_rk_data(data[2]), .o_done(done[2]));

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        bit           known;
    } beat_t;

    beat_t        sbq [3][$];
    int           checks = 0, errors = 0, cyc = 0;
    int           acc [3], dcnt [3], s_edge [3];
    bit [2:0]     tchk;
    bit           rmode;
    logic [2:0]   p_vld, p_rdy;
    logic         p_rst;
    logic [3:0]   p_idx [3];
    logic [127:0] p_data [3];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Push the expected beat sequence for instance d (NK = 4, 6, 8).
    task automatic push_seq(input int d);
        beat_t b;
        for (int k = 0; k <= 10 + 2 * d; k++) begin
            b.idx = 4'(k); b.data = 128'h0; b.known = 1'b1;
            if (d == 0) b.data = EXP4[k];
            else if (d == 1) begin
                case (k)
                    0:       b.data = 128'h8e73b0f7da0e6452c810f32b809079e5;
                    1:       b.data = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
                    2:       b.data = 128'hec12068e6c827f6b0e7a95b95c56fec2;
                    12:      b.data = 128'he98ba06f448c773c8ecc720401002202;
                    default: b.known = 1'b0;
                endcase
            end else begin
                case (k)
                    0:       b.data = 128'h603deb1015ca71be2b73aef0857d7781;
                    1:       b.data = 128'h1f352c073b6108d72d9810a30914dff4;
                    2:       b.data = 128'h9ba354118e6925afa51a8b5f2067fcde;
                    3:       b.data = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
                    14:      b.data = 128'hfe4890d1e6188d0b046df344706c631e;
                    default: b.known = 1'b0;
                endcase
            end
            sbq[d].push_back(b);
        end
    endtask

    task automatic pulse_start(input logic [2:0] m);
        start = m;
        @(posedge clk); #1;
        start = 3'b000;
        for (int d = 0; d < 3; d++) if (m[d]) s_edge[d] = cyc;
    endtask

    task automatic wait_done(input int d, input int n);
        int t = 0;
        while (dcnt[d] < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("done_seen_nk%0d", 4 + 2 * d), 128'(dcnt[d] >= n), 128'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every handshake and checks stall stability and done.
    always @(negedge clk) begin
        beat_t b;
        for (int d = 0; d < 3; d++) begin
            if (p_vld[d] && !p_rdy[d] && !p_rst && !rst) begin
                check("stall_valid", 128'(vld[d]), 128'd1);
                check("stall_index", 128'(idx[d]), 128'(p_idx[d]));
                check("stall_data", data[d], p_data[d]);
            end
            if (vld[d] && rdy[d] && !rst) begin
                acc[d]++;
                if (sbq[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat nk%0d actual_index=%0d required=none", 4 + 2 * d, idx[d]);
                end else begin
                    b = sbq[d].pop_front();
                    check($sformatf("rk_index_nk%0d", 4 + 2 * d), 128'(idx[d]), 128'(b.idx));
                    if (b.known) check($sformatf("rk_data_nk%0d_b%0d", 4 + 2 * d, b.idx), data[d], b.data);
                    if (tchk[d]) check("beat_cycle", 128'(cyc - s_edge[d]), 128'(4 * (int'(b.idx) + 1)));
                end
            end
            if (done[d]) begin
                dcnt[d]++;
                check("done_queue_empty", 128'(sbq[d].size()), 128'd0);
                if (tchk[d]) check("done_cycle", 128'(cyc - s_edge[d]), 128'(4 * (11 + 2 * d) + 1));
            end
            p_idx[d]  <= idx[d];
            p_data[d] <= data[d];
        end
        p_vld <= vld;
        p_rdy <= rdy;
        p_rst <= rst;
    end

    // Ready driver: instance 0 gets ~30% random backpressure when rmode is set.
    initial begin
        rdy = 3'b111;
        forever begin
            @(posedge clk); #1;
            rdy[0] = rmode ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    initial begin
        rst = 1'b1; start = 3'b000; tchk = 3'b000; rmode = 1'b0;
        key4 = KEY4; key6 = KEY6; key8 = KEY8;
        for (int d = 0; d < 3; d++) begin acc[d] = 0; dcnt[d] = 0; s_edge[d] = 0; end
`ifdef KEYEXP_STORE_EN
        for (int d = 0; d < 3; d++) rd_idx[d] = 4'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", 128'(busy[d]), 128'd0);
            check("rst_valid", 128'(vld[d]), 128'd0);
            check("rst_index", 128'(idx[d]), 128'd0);
            check("rst_data", data[d], 128'h0);
            check("rst_done", 128'(done[d]), 128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Full expansions on all three sizes, ready tied high, with late key change and stray start.
        for (int d = 0; d < 3; d++) push_seq(d);
        tchk = 3'b111;
        pulse_start(3'b111);
        key4 = '1; key6 = '1; key8 = '1;
        repeat (8) @(posedge clk);
        #1;
        check("busy_run", 128'(busy), 128'(3'b111));
        start = 3'b111;
        @(posedge clk); #1;
        start = 3'b000;
        for (int d = 0; d < 3; d++) wait_done(d, 1);
        @(negedge clk);
        check("busy_after_done", 128'(busy), 128'd0);
        check("valid_after_done", 128'(vld), 128'd0);

        // Random backpressure on NK=4.
        key4 = KEY4; tchk = 3'b000; rmode = 1'b1;
        push_seq(0);
        @(posedge clk); #1;
        pulse_start(3'b001);
        wait_done(0, 2);
        rmode = 1'b0;

        // Reset after beat 3, then a clean restart.
        tchk[0] = 1'b1;
        push_seq(0);
        @(posedge clk); #1;
        pulse_start(3'b001);
        for (int t = 0; t < 100 && acc[0] < 11 * 2 + 4; t++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq[0].delete();
        @(negedge clk);
        check("midrst_busy", 128'(busy[0]), 128'd0);
        check("midrst_valid", 128'(vld[0]), 128'd0);
        check("midrst_index", 128'(idx[0]), 128'd0);
        check("midrst_data", data[0], 128'h0);
        check("midrst_done", 128'(done[0]), 128'd0);
        push_seq(0);
        @(posedge clk); #1;
        pulse_start(3'b001);
        wait_done(0, 3);

`ifdef KEYEXP_STORE_EN
        @(negedge clk);
        check("keys_valid_set", 128'(kv[0]), 128'd1);
        rd_idx[0] = 4'd10; #1;
        check("rd_key_10", rd_key[0], EXP4[10]);
        rd_idx[0] = 4'd3; #1;
        check("rd_key_3", rd_key[0], EXP4[3]);
        rd_idx[0] = 4'd15; #1;
        check("rd_key_15", rd_key[0], 128'h0);
        @(posedge clk); #1;
        pulse_start(3'b001);
        check("keys_valid_clr", 128'(kv[0]), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq[0].delete();
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
